// File: rtl/fir_mc_if.sv
// fir_mc_if -- stream bundle for fir_mc_datapath.
// Carries the coefficient load stream, the sample input stream, the result
// stream and the status flags. The master side drives the filter's inputs,
// and the slave side is the filter itself.
interface fir_mc_if #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int MAX_TAPS = 16,
  parameter int NUM_CH   = 2
);
  localparam int TC_W = $clog2(MAX_TAPS + 1);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Coefficient stream, h[0] first.
  logic [TC_W-1:0]   tap_count;
  logic              coeff_clear;
  logic              coeff_valid;
  logic              coeff_ready;
  logic [COEF_W-1:0] coeff_data;
  logic              coeff_load_done;

  // Sample stream.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CH_W-1:0]   in_ch;

  // Result stream.
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;

  // Status.
  logic              busy;
  logic              err_ch;

  modport master (
    output tap_count, coeff_clear, coeff_valid, coeff_data,
    output in_valid, in_data, in_ch, out_ready,
    input  coeff_ready, coeff_load_done, in_ready,
    input  out_valid, out_data, out_ch, busy, err_ch
  );

  modport slave (
    input  tap_count, coeff_clear, coeff_valid, coeff_data,
    input  in_valid, in_data, in_ch, out_ready,
    output coeff_ready, coeff_load_done, in_ready,
    output out_valid, out_data, out_ch, busy, err_ch
  );
endinterface

// File: rtl/fir_mc_datapath.sv
// fir_mc_datapath -- multi-channel FIR filter built around one shared multiplier.
// Coefficients are loaded once and shared by all channels. Each channel keeps
// its own delay line. A sample is accepted in IDLE. The filter then spends N
// cycles in MAC, one product per cycle, and presents the rounded and shifted
// result in OUT until it is taken.
// Optional feature: define FIR_SATURATE_EN to clamp the result to the DATA_W
// signed range. When the macro is undefined, the result wraps to its low
// DATA_W bits.
module fir_mc_datapath #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int MAX_TAPS  = 16,
  parameter int NUM_CH    = 2,
  parameter int OUT_SHIFT = 15
) (
  input  logic     clk,
  input  logic     rst,
  fir_mc_if.slave  bus
);
  localparam int TC_W   = $clog2(MAX_TAPS + 1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W  = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(MAX_TAPS);
  // One extra bit so that adding the rounding constant cannot overflow.
  localparam int SUM_W  = ACC_W + 1;
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic signed [SUM_W-1:0] RND =
    (OUT_SHIFT > 0) ? (SUM_W'(1) << RND_SH) : '0;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_MAC, S_OUT} state_t;

  state_t state, state_nxt;

  logic signed [COEF_W-1:0] h_mem [MAX_TAPS];
  logic signed [DATA_W-1:0] x_mem [NUM_CH][MAX_TAPS];

  logic [IDX_W-1:0]         n_last;     // N-1 for the loaded filter
  logic [IDX_W-1:0]         load_last;  // N-1 seen by the current load beat
  logic [IDX_W-1:0]         load_idx;
  logic [IDX_W-1:0]         mac_idx;
  logic [CH_W-1:0]          cur_ch;
  logic [CH_W-1:0]          out_ch_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     load_done_q;
  logic                     err_ch_q;

  logic coeff_fire, load_end, in_fire, ch_ok, mac_end, out_fire;

  // Round, shift, then saturate or wrap to DATA_W.
  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [ACC_W-1:0] a);
    logic signed [SUM_W-1:0] sum;
    sum = SUM_W'(a) + RND;
`ifdef FIR_SATURATE_EN
    if ((sum >>> OUT_SHIFT) > SAT_MAX)      return DATA_W'(SAT_MAX);
    else if ((sum >>> OUT_SHIFT) < SAT_MIN) return DATA_W'(SAT_MIN);
    else                                    return DATA_W'(sum >>> OUT_SHIFT);
`else
    return DATA_W'(sum >>> OUT_SHIFT);
`endif
  endfunction

  assign coeff_fire = (state == S_LOAD) && bus.coeff_valid;
  assign load_end   = coeff_fire && (load_idx == load_last);
  assign in_fire    = (state == S_IDLE) && bus.in_valid;
  assign ch_ok      = {1'b0, bus.in_ch} < (CH_W+1)'(NUM_CH);
  assign mac_end    = (state == S_MAC) && (mac_idx == n_last);
  assign out_fire   = (state == S_OUT) && bus.out_ready;

  assign prod    = h_mem[mac_idx] * x_mem[cur_ch][mac_idx];
  assign acc_nxt = acc + ACC_W'(prod);

  // Filter length: tap_count is clamped into 1..MAX_TAPS on the first beat only.
  always_comb begin
    // NOTE: give every combinational output a default first so no path can infer a latch.
    load_last = n_last;
    if (load_idx == '0) begin
      if (bus.tap_count == '0)                      load_last = '0;
      else if (bus.tap_count > TC_W'(MAX_TAPS))     load_last = IDX_W'(MAX_TAPS - 1);
      else                                          load_last = IDX_W'(bus.tap_count - 1'b1);
    end
  end

  // Next-state logic. coeff_clear overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (load_end)          state_nxt = S_IDLE;
      S_IDLE:  if (in_fire && ch_ok)  state_nxt = S_MAC;
      S_MAC:   if (mac_end)           state_nxt = S_OUT;
      S_OUT:   if (out_fire)          state_nxt = S_IDLE;
      default:                        state_nxt = S_LOAD;
    endcase
    if (bus.coeff_clear) state_nxt = S_LOAD;
  end

  // State register. rst takes priority over coeff_clear.
  always_ff @(posedge clk) begin
    // NOTE: use non-blocking assignments for all clocked state so every flop samples pre-edge values.
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // Coefficient store, delay lines, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these memories are reset on purpose. The reset state and coeff_clear both require zeroed history.
      for (int i = 0; i < MAX_TAPS; i++) h_mem[i] <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int i = 0; i < MAX_TAPS; i++) x_mem[c][i] <= '0;
      n_last      <= '0;
      load_idx    <= '0;
      mac_idx     <= '0;
      cur_ch      <= '0;
      acc         <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      load_done_q <= 1'b0;
      err_ch_q    <= 1'b0;
    end else begin
      err_ch_q <= 1'b0;
      if (bus.coeff_clear) begin
        for (int i = 0; i < MAX_TAPS; i++) h_mem[i] <= '0;
        for (int c = 0; c < NUM_CH; c++)
          for (int i = 0; i < MAX_TAPS; i++) x_mem[c][i] <= '0;
        load_idx    <= '0;
        mac_idx     <= '0;
        acc         <= '0;
        load_done_q <= 1'b0;
      end else begin
        case (state)
          S_LOAD: begin
            if (coeff_fire) begin
              h_mem[load_idx] <= $signed(bus.coeff_data);
              if (load_idx == '0) n_last <= load_last;
              if (load_end) begin
                load_idx    <= '0;
                load_done_q <= 1'b1;
              end else begin
                load_idx <= load_idx + 1'b1;
              end
            end
          end
          S_IDLE: begin
            if (in_fire) begin
              if (ch_ok) begin
                for (int k = MAX_TAPS - 1; k > 0; k--)
                  x_mem[bus.in_ch][k] <= x_mem[bus.in_ch][k-1];
                x_mem[bus.in_ch][0] <= $signed(bus.in_data);
                cur_ch  <= bus.in_ch;
                acc     <= '0;
                mac_idx <= '0;
              end else begin
                err_ch_q <= 1'b1;
              end
            end
          end
          S_MAC: begin
            acc <= acc_nxt;
            if (mac_end) begin
              out_data_q <= reduce(acc_nxt);
              out_ch_q   <= cur_ch;
            end else begin
              mac_idx <= mac_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.coeff_ready     = (state == S_LOAD);
  assign bus.coeff_load_done = load_done_q;
  assign bus.in_ready        = (state == S_IDLE);
  assign bus.out_valid       = (state == S_OUT);
  assign bus.out_data        = out_data_q;
  assign bus.out_ch          = out_ch_q;
  assign bus.busy            = (state == S_MAC) || (state == S_OUT);
  assign bus.err_ch          = err_ch_q;
endmodule

// File: tb/tb_fir_mc_datapath.sv
// tb_fir_mc_datapath -- directed bench for fir_mc_datapath with OUT_SHIFT=0.
// NUM_CH is 3, which gives a 2-bit channel field. This makes in_ch=3 an
// invalid channel, so the invalid-channel path can be exercised.
// The N=2 full-scale case takes its expected values from FIR_SATURATE_EN.
module tb_fir_mc_datapath;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int MAX_TAPS  = 16;
  localparam int NUM_CH    = 3;
  localparam int OUT_SHIFT = 0;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   coef_tab [MAX_TAPS];

  fir_mc_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .MAX_TAPS(MAX_TAPS), .NUM_CH(NUM_CH)) bus ();

  fir_mc_datapath #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .MAX_TAPS(MAX_TAPS),
    .NUM_CH(NUM_CH), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_clear();
    bus.coeff_clear = 1'b1;
    @(posedge clk); #1;
    bus.coeff_clear = 1'b0;
  endtask

  task automatic send_coeff(input string tag, input int c);
    int t = 0;
    bus.coeff_valid = 1'b1;
    bus.coeff_data  = 16'(c);
    while (!bus.coeff_ready && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) check({tag, "_coeff_timeout"}, 32'(t), 32'd0);
    @(posedge clk); #1;
    bus.coeff_valid = 1'b0;
  endtask

  // Load coef_tab[0..n_send-1] with the given tap_count.
  task automatic load_coeffs(input string tag, input int tc, input int n_send);
    bus.tap_count = 5'(tc);
    for (int i = 0; i < n_send; i++) begin
      if (i == n_send - 1 && n_send > 1)
        check({tag, "_done_early"}, 32'(bus.coeff_load_done), 32'd0);
      send_coeff(tag, coef_tab[i]);
    end
    check({tag, "_done"}, 32'(bus.coeff_load_done), 32'd1);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic accept_sample(input string tag, input int ch, input int val);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_ch    = 2'(ch);
    bus.in_data  = 16'(val);
    while (!bus.in_ready && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) check({tag, "_in_timeout"}, 32'(t), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Send one sample, then check the latency, the result and the channel.
  // Hold out_ready low for 'hold' cycles, then take the result.
  task automatic run_sample(input string tag, input int ch, input int val,
                            input int exp_val, input int exp_ch, input int n, input int hold);
    int lat = 0;
    accept_sample(tag, ch, val);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end while (!bus.out_valid && lat < 64);
    check({tag, "_lat"}, 32'(lat), 32'(n + 1));
    check({tag, "_data"}, 32'(bus.out_data), 32'(16'(exp_val)));
    check({tag, "_ch"}, 32'(bus.out_ch), 32'(exp_ch));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_data"}, 32'(bus.out_data), 32'(16'(exp_val)));
      check({tag, "_hold_ch"}, 32'(bus.out_ch), 32'(exp_ch));
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Count the cycles in which out_valid is seen over a window.
  task automatic expect_no_output(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check({tag, "_no_out"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int sat1, sat2;
`ifdef FIR_SATURATE_EN
    sat1 = 32767; sat2 = 32767;
`else
    sat1 = 1;     sat2 = 2;
`endif
    rst             = 1'b1;
    bus.tap_count   = '0;
    bus.coeff_clear = 1'b0;
    bus.coeff_valid = 1'b0;
    bus.coeff_data  = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_ch       = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state.
    check("rst_coeff_ready", 32'(bus.coeff_ready),     32'd1);
    check("rst_load_done",   32'(bus.coeff_load_done), 32'd0);
    check("rst_in_ready",    32'(bus.in_ready),        32'd0);
    check("rst_out_valid",   32'(bus.out_valid),       32'd0);
    check("rst_out_data",    32'(bus.out_data),        32'd0);
    check("rst_out_ch",      32'(bus.out_ch),          32'd0);
    check("rst_busy",        32'(bus.busy),            32'd0);
    check("rst_err_ch",      32'(bus.err_ch),          32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // N=4, h=[1,2,3,4], then the impulse response on ch0.
    coef_tab[0] = 1; coef_tab[1] = 2; coef_tab[2] = 3; coef_tab[3] = 4;
    load_coeffs("load4", 4, 4);
    run_sample("imp0", 0, 1, 1, 0, 4, 0);
    run_sample("imp1", 0, 0, 2, 0, 4, 0);
    run_sample("imp2", 0, 0, 3, 0, 4, 0);
    run_sample("imp3", 0, 0, 4, 0, 4, 0);
    run_sample("imp4", 0, 0, 0, 0, 4, 0);

    // Channels keep independent histories.
    run_sample("mc_a", 0, 10,  10,  0, 4, 0);
    run_sample("mc_b", 1, 100, 100, 1, 4, 0);
    run_sample("mc_c", 0, 0,   20,  0, 4, 0);

    // Backpressure: the result is held for 5 cycles (ch1 history [0,100] gives 200).
    run_sample("hold", 1, 0, 200, 1, 4, 5);

    // Invalid channel: accepted and dropped, with an err_ch pulse.
    accept_sample("badch", 3, 5000);
    check("badch_err",      32'(bus.err_ch),    32'd1);
    check("badch_in_ready", 32'(bus.in_ready),  32'd1);
    check("badch_busy",     32'(bus.busy),      32'd0);
    @(posedge clk); #1;
    check("badch_err_once", 32'(bus.err_ch),    32'd0);
    expect_no_output("badch", 6);
    // ch0 history [0,10,0,0] shifts to [0,0,10,0], giving 3*10.
    run_sample("after_bad", 0, 0, 30, 0, 4, 0);

    // coeff_clear during the second MAC cycle.
    accept_sample("clr", 0, 7);
    @(posedge clk); #1;
    bus.coeff_clear = 1'b1;
    @(posedge clk); #1;
    bus.coeff_clear = 1'b0;
    check("clr_coeff_ready", 32'(bus.coeff_ready),     32'd1);
    check("clr_load_done",   32'(bus.coeff_load_done), 32'd0);
    check("clr_busy",        32'(bus.busy),            32'd0);
    check("clr_in_ready",    32'(bus.in_ready),        32'd0);
    expect_no_output("clr", 8);
    load_coeffs("reload4", 4, 4);
    run_sample("zh0", 0, 1, 1, 0, 4, 0);
    run_sample("zh1", 0, 0, 2, 0, 4, 0);

    // rst in the middle of MAC discards the pending result.
    accept_sample("rmac", 1, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rmac_coeff_ready", 32'(bus.coeff_ready),     32'd1);
    check("rmac_load_done",   32'(bus.coeff_load_done), 32'd0);
    check("rmac_busy",        32'(bus.busy),            32'd0);
    check("rmac_out_data",    32'(bus.out_data),        32'd0);
    expect_no_output("rmac", 8);

    // N=2 with full-scale values: the result saturates or wraps.
    coef_tab[0] = 32767; coef_tab[1] = 32767;
    load_coeffs("load2", 2, 2);
    run_sample("fs0", 0, 32767, sat1, 0, 2, 0);
    run_sample("fs1", 0, 32767, sat2, 0, 2, 0);

    // tap_count=0 behaves as N=1.
    pulse_clear();
    coef_tab[0] = 3;
    load_coeffs("tc0", 0, 1);
    run_sample("tc0_s", 1, 5, 15, 1, 1, 0);

    // tap_count above MAX_TAPS behaves as N=MAX_TAPS.
    pulse_clear();
    for (int k = 0; k < MAX_TAPS; k++) coef_tab[k] = k + 1;
    load_coeffs("tcmax", 31, MAX_TAPS);
    run_sample("tcmax_s0", 0, 2, 2, 0, MAX_TAPS, 0);
    run_sample("tcmax_s1", 0, 0, 4, 0, MAX_TAPS, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
